disp_word_queue: RTL

//  Upstream feeder for the 7-segment hex display stage. Buffers 32-bit debug words

---
 rtl/disp_pkg.sv | 15 +
 rtl/disp_fifo.sv | 69 ++++++
 rtl/disp_word_queue.sv | 130 +++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the debug-word display queue.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package disp_pkg;

   localparam int DISP_WORD_W   = 32;
   // 8 nibbles x 2^27 cycles each
   localparam int DEFAULT_DWELL = 1073741824;

   typedef enum logic {
      IDLE = 1'b0,
      SHOW = 1'b1
   } disp_state_e;

endpackage

// File: rtl/disp_fifo.sv
// Synchronous FIFO of display words; head is read combinationally.
// Latency: a push is visible at the head the cycle after the push edge.
// Backpressure: a push while full is ignored unless a pop happens in the same cycle.
module disp_fifo
   import disp_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [DISP_WORD_W-1:0]     push_dat,
   input  logic                       pop,
   output logic [DISP_WORD_W-1:0]     head_dat,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [DISP_WORD_W-1:0] mem_q [DEPTH];
   logic [DISP_WORD_W-1:0] mem_d [DEPTH];
   logic [AW:0]            wr_ptr_q, wr_ptr_d;
   logic [AW:0]            rd_ptr_q, rd_ptr_d;
   logic                   push_ok;
   logic                   pop_ok;

   // Pointers carry one extra MSB so full and empty are distinguishable.
   assign count    = wr_ptr_q - rd_ptr_q;
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (count == (AW+1)'(DEPTH));
   assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

   // When full, the slot being written is the head being popped this same cycle.
   assign pop_ok   = pop && !empty;
   assign push_ok  = push && (!full || pop_ok);

   // Next-state for pointers and storage.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         mem_d[wr_ptr_q[AW-1:0]] = push_dat;
         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   // Pointer registers; reset flushes the queue.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/disp_word_queue.sv
// Queues 32-bit debug words and shows each for DWELL_CYCLES on char/char_valid; optional skip input under DISP_QUEUE_SKIP_EN.
// Latency: write into an empty idle queue appears on char one cycle after the write edge.
// Backpressure: wr_ready = !full || pop; writes while not ready are dropped and set sticky overflow.
module disp_word_queue
   import disp_pkg::*;
#(
   parameter int DEPTH        = 8,
   parameter int DWELL_CYCLES = DEFAULT_DWELL
) (
   input  logic                       clk,
   input  logic                       reset,
`ifdef DISP_QUEUE_SKIP_EN
   input  logic                       skip,
`endif
   input  logic                       wr_valid,
   input  logic [DISP_WORD_W-1:0]     wr_data,
   output logic                       wr_ready,
   output logic [DISP_WORD_W-1:0]     char,
   output logic                       char_valid,
   output logic [$clog2(DEPTH):0]     q_count,
   output logic                       overflow
);

   localparam int              DW_W         = $clog2(DWELL_CYCLES) + 1;
   localparam logic [DW_W-1:0] DWELL_RELOAD = DW_W'(DWELL_CYCLES - 1);

   disp_state_e            state_q, state_d;
   logic [DW_W-1:0]        dwell_q, dwell_d;
   logic [DISP_WORD_W-1:0] char_q, char_d;
   logic                   char_vld_q, char_vld_d;
   logic                   overflow_q, overflow_d;

   logic                   pop;
   logic                   push;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [DISP_WORD_W-1:0] head_dat;
   logic                   skip_hit;

`ifdef DISP_QUEUE_SKIP_EN
   assign skip_hit = skip;
`else
   assign skip_hit = 1'b0;
`endif

   assign wr_ready   = !fifo_full || pop;
   assign push       = wr_valid && wr_ready;
   assign char       = char_q;
   assign char_valid = char_vld_q;
   assign overflow   = overflow_q;

   disp_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_dat (wr_data),
      .pop      (pop),
      .head_dat (head_dat),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (q_count)
   );

   // Display FSM: load a word, count down its dwell, then advance or go idle.
   always_comb begin
      state_d    = state_q;
      dwell_d    = dwell_q;
      char_d     = char_q;
      char_vld_d = char_vld_q;
      pop        = 1'b0;
      case (state_q)
         IDLE: begin
            char_vld_d = 1'b0;
            if (!fifo_empty) begin
               pop        = 1'b1;
               char_d     = head_dat;
               char_vld_d = 1'b1;
               dwell_d    = DWELL_RELOAD;
               state_d    = SHOW;
            end
         end
         SHOW: begin
            if (dwell_q == '0 || skip_hit) begin
               if (!fifo_empty) begin
                  // Back-to-back: char_valid stays high across the swap.
                  pop     = 1'b1;
                  char_d  = head_dat;
                  dwell_d = DWELL_RELOAD;
               end else begin
                  // Last word stays on char after valid drops.
                  char_vld_d = 1'b0;
                  dwell_d    = '0;
                  state_d    = IDLE;
               end
            end else begin
               dwell_d = dwell_q - DW_W'(1);
            end
         end
         default: begin
            state_d    = IDLE;
            char_vld_d = 1'b0;
         end
      endcase
   end

   // A write is lost exactly when it is offered while the queue cannot take it.
   always_comb begin
      overflow_d = overflow_q || (wr_valid && !wr_ready);
   end

   // State registers; reset abandons the shown word.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         dwell_q    <= '0;
         char_q     <= '0;
         char_vld_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         dwell_q    <= dwell_d;
         char_q     <= char_d;
         char_vld_q <= char_vld_d;
         overflow_q <= overflow_d;
      end
   end

endmodule
